// File: rtl/imm_ctrl_pkg.sv
// imm_ctrl_pkg: shared opcode constants, FSM state, format and select types
//   for the decode-stage immediate controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: OPC_W, opcode localparams, state_e {RUN, STALL, FLUSH},
//   fmt_e (immediate format class), sel_t (one-hot select bundle),
//   opc_to_fmt() and fmt_to_sel() helpers.
package imm_ctrl_pkg;

  // Opcode field width, fixed by the ISA.
  localparam int OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Controller sequencing state.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Immediate format class of an opcode. FMT_BAD marks opcodes outside
  // the supported set.
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_SB  = 3'd3,
    FMT_U   = 3'd4,
    FMT_UJ  = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  // One-hot format selects toward the immediate generator.
  typedef struct packed {
    logic iload;
    logic s;
    logic sb;
    logic u;
    logic uj;
  } sel_t;

  function automatic fmt_e opc_to_fmt(input logic [OPC_W-1:0] opc);
    fmt_e f;
    unique case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
      OPC_STORE:                                 f = FMT_S;
      OPC_BRANCH:                                f = FMT_SB;
      OPC_LUI, OPC_AUIPC:                        f = FMT_U;
      OPC_JAL:                                   f = FMT_UJ;
      OPC_OP:                                    f = FMT_R;
      default:                                   f = FMT_BAD;
    endcase
    return f;
  endfunction

  // Each format maps to at most one select bit, so the result is one-hot
  // or all zero by construction.
  function automatic sel_t fmt_to_sel(input fmt_e f);
    sel_t s;
    s = '0;
    unique case (f)
      FMT_I:   s.iload = 1'b1;
      FMT_S:   s.s     = 1'b1;
      FMT_SB:  s.sb    = 1'b1;
      FMT_U:   s.u     = 1'b1;
      FMT_UJ:  s.uj    = 1'b1;
      default: s       = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode: opcode -> one-hot immediate-format selects (+illegal flag).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
// Ports: i_opcode (OPC_W) in; o_sel (sel_t) out; o_illegal out.
// Macro IMM_ILLEGAL_TRAP_EN: when defined, unsupported opcodes raise
//   o_illegal; otherwise they decode as R-type and o_illegal stays 0.
module imm_fmt_decode
  import imm_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output sel_t             o_sel,
  output logic             o_illegal
);

  fmt_e w_fmt;

  assign w_fmt = opc_to_fmt(i_opcode);
  // FMT_BAD yields all-zero selects, which is also the R-type result.
  assign o_sel = fmt_to_sel(w_fmt);

`ifdef IMM_ILLEGAL_TRAP_EN
  assign o_illegal = (w_fmt == FMT_BAD);
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer feeding the immediate generator and
//   the ID/EX boundary; sequences load-use stalls and branch flushes.
// Latency: 1 cycle from an accepted instruction to its registered selects.
// Backpressure: inst_ready drops while stalling/flushing, on hazard or branch
//   inputs, and while a live entry is waiting for ex_ready.
// Ports: clk, rst (sync, active-high); inst_valid/inst_ready/inst fetch
//   handshake; load_use_hz, branch_taken, ex_ready sequencing inputs;
//   imm_inst, ILoad/S/SB/U/UJ, nop, dec_valid, illegal decode outputs.
// Macro IMM_ILLEGAL_TRAP_EN: latches an illegal flag for unsupported opcodes.
module imm_decode_ctrl
  import imm_ctrl_pkg::*;
#(
  // Bubble cycles inserted after branch_taken; must be at least 1.
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic        load_use_hz,
  input  logic        branch_taken,
  input  logic        ex_ready,
  output logic [24:0] imm_inst,
  output logic        ILoad,
  output logic        S,
  output logic        SB,
  output logic        U,
  output logic        UJ,
  output logic        nop,
  output logic        dec_valid,
  output logic        illegal
);

  // Counter holds FLUSH_CYCLES-1 down to 0, so clog2(FLUSH_CYCLES) bits do.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e           r_state;
  logic             r_dec_valid;
  logic [24:0]      r_imm_inst;
  sel_t             r_sel;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  sel_t             w_sel;
  logic             w_illegal;
  logic             w_inst_ready;
  logic             w_accept;

  imm_fmt_decode u_fmt_decode (
    .i_opcode  (inst[OPC_W-1:0]),
    .o_sel     (w_sel),
    .o_illegal (w_illegal)
  );

  // A live entry blocks a new one until EX takes it; the hazard and branch
  // terms keep a same-cycle event from racing an accept.
  assign w_inst_ready = (r_state == RUN) & ~load_use_hz & ~branch_taken &
                        (ex_ready | ~r_dec_valid);
  assign w_accept     = inst_valid & w_inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_dec_valid <= 1'b0;
      r_imm_inst  <= '0;
      r_sel       <= '0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
    end else if (branch_taken) begin
      // Taken branch wins from any state; re-entering FLUSH reloads the
      // counter so the bubble window restarts.
      r_state     <= FLUSH;
      r_dec_valid <= 1'b0;
      r_imm_inst  <= '0;
      r_sel       <= '0;
      r_illegal   <= 1'b0;
      r_cnt       <= CNT_LOAD;
    end else begin
      unique case (r_state)
        RUN: begin
          if (load_use_hz) begin
            // Decode register is frozen; it is re-presented after the stall.
            r_state <= STALL;
          end else if (w_accept) begin
            r_dec_valid <= 1'b1;
            r_imm_inst  <= inst[31:7];
            r_sel       <= w_sel;
            r_illegal   <= w_illegal;
          end else if (ex_ready && r_dec_valid) begin
            // Drain: EX consumed the entry and nothing replaces it.
            r_dec_valid <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        STALL: begin
          if (!load_use_hz) begin
            r_state <= RUN;
          end
        end
        FLUSH: begin
          if (r_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign inst_ready = w_inst_ready;
  assign dec_valid  = r_dec_valid;
  assign imm_inst   = r_imm_inst;
  assign ILoad      = r_sel.iload;
  assign S          = r_sel.s;
  assign SB         = r_sel.sb;
  assign U          = r_sel.u;
  assign UJ         = r_sel.uj;
  assign illegal    = r_illegal;
  // Built only from registers: no input reaches nop combinationally.
  assign nop        = ~r_dec_valid | (r_state != RUN);

  // Selects are loaded only from fmt_to_sel() or cleared.
  a_sel_onehot0 : assert property (@(posedge clk) disable iff (rst)
                                   $onehot0(r_sel));

endmodule
